// File: rtl/simprisc_chk_pkg.sv
// Shared types and default parameters for the simprisc stream checker.
package simprisc_chk_pkg;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_MISMATCH  = 2'd1,
        ERR_UNDERFLOW = 2'd2
    } err_code_t;

    localparam int DEF_DATA_W  = 8;
    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_TIMEOUT = 64;
    localparam int DEF_CNT_W   = 16;

endpackage

// File: rtl/simprisc_chk_fifo.sv
// Per-channel expected-value queue: circular buffer with wrapping pointers and
// an explicit fill count, so full/empty are single compares on a register.
module simprisc_chk_fifo
    import simprisc_chk_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [AW:0]       count_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (count_r == DEPTH[AW:0]);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // pointer and fill-level update; clear flushes like reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (clear) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
            count_r <= count_r + (AW+1)'(do_push_s) - (AW+1)'(do_pop_s);
        end
    end

    // storage array; contents are only meaningful below the fill count
    always_ff @(posedge clk) begin
        if (do_push_s && !clear) mem_r[wr_ptr_r] <= din;
    end

endmodule

// File: rtl/simprisc_stream_checker.sv
// In-order expected/actual stream checker: per-channel queues, registered
// compare stage, per-channel head-age timeouts and saturating counters.
module simprisc_stream_checker
    import simprisc_chk_pkg::*;
#(
    parameter int  DATA_W  = DEF_DATA_W,
    parameter int  NUM_CH  = DEF_NUM_CH,
    parameter int  DEPTH   = DEF_DEPTH,
    parameter int  TIMEOUT = DEF_TIMEOUT,
    parameter int  CNT_W   = DEF_CNT_W,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              exp_valid,
    input  logic [CH_W-1:0]   exp_ch,
    input  logic [DATA_W-1:0] exp_data,
    output logic              exp_ready,
    input  logic              act_valid,
    input  logic [CH_W-1:0]   act_ch,
    input  logic [DATA_W-1:0] act_data,
    output logic              err_valid,
    output logic [1:0]        err_code,
    output logic [CH_W-1:0]   err_ch,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_act,
    output logic [NUM_CH-1:0] timeout_flags,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic              empty_all
);

    localparam int              SLOTS    = 1 << CH_W;
    localparam int              AGE_W    = $clog2(TIMEOUT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(TIMEOUT);
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W+1)'(NUM_CH);

    // Unused channel slots (NUM_CH not a power of two) read as full and empty.
    logic [SLOTS-1:0]             full_s;
    logic [SLOTS-1:0]             empty_s;
    logic [SLOTS-1:0]             push_vec_s;
    logic [SLOTS-1:0]             pop_vec_s;
    logic [SLOTS-1:0][DATA_W-1:0] head_s;
    logic                         exp_ch_ok_s;
    logic                         act_ok_s;
    logic                         act_empty_s;
    logic                         act_eq_s;

    err_code_t         err_code_r;
    logic              err_valid_r;
    logic [CH_W-1:0]   err_ch_r;
    logic [DATA_W-1:0] err_exp_r;
    logic [DATA_W-1:0] err_act_r;
    logic [CNT_W-1:0]  match_cnt_r;
    logic [CNT_W-1:0]  mismatch_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign exp_ch_ok_s = ({1'b0, exp_ch} < NUM_CH_L);
    assign exp_ready   = exp_ch_ok_s && !full_s[exp_ch];
    assign act_ok_s    = act_valid && ({1'b0, act_ch} < NUM_CH_L) && !clear;
    assign act_empty_s = empty_s[act_ch];
    assign act_eq_s    = (head_s[act_ch] == act_data);
    assign empty_all   = &empty_s;

    // decode the single push and single pop into per-channel strobes
    always_comb begin
        push_vec_s         = {SLOTS{1'b0}};
        pop_vec_s          = {SLOTS{1'b0}};
        push_vec_s[exp_ch] = exp_valid && exp_ready && !clear;
        pop_vec_s[act_ch]  = act_ok_s && !act_empty_s;
    end

    for (genvar c = 0; c < SLOTS; c++) begin : g_ch
        if (c < NUM_CH) begin : g_q
            logic [AGE_W-1:0] age_r;
            logic [AGE_W-1:0] age_next_s;
            logic             flag_r;

            simprisc_chk_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .clear (clear),
                .push  (push_vec_s[c]),
                .pop   (pop_vec_s[c]),
                .din   (exp_data),
                .head  (head_s[c]),
                .full  (full_s[c]),
                .empty (empty_s[c])
            );

            // head age restarts whenever a new entry becomes head or none waits
            always_comb begin
                if (pop_vec_s[c] || empty_s[c]) begin
                    age_next_s = {AGE_W{1'b0}};
                end else if (age_r == AGE_MAX) begin
                    age_next_s = AGE_MAX;
                end else begin
                    age_next_s = age_r + AGE_W'(1);
                end
            end

            // age counter and sticky timeout flag
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    age_r  <= {AGE_W{1'b0}};
                    flag_r <= 1'b0;
                end else if (clear) begin
                    age_r  <= {AGE_W{1'b0}};
                    flag_r <= 1'b0;
                end else begin
                    age_r  <= age_next_s;
                    flag_r <= flag_r | (age_next_s == AGE_MAX);
                end
            end

            assign timeout_flags[c] = flag_r;
        end else begin : g_pad
            assign full_s[c]  = 1'b1;
            assign empty_s[c] = 1'b1;
            assign head_s[c]  = {DATA_W{1'b0}};
        end
    end

    // compare stage: one registered report and counter update per actual
    always_ff @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            err_valid_r    <= 1'b0;
            err_code_r     <= ERR_NONE;
            err_ch_r       <= {CH_W{1'b0}};
            err_exp_r      <= {DATA_W{1'b0}};
            err_act_r      <= {DATA_W{1'b0}};
            match_cnt_r    <= {CNT_W{1'b0}};
            mismatch_cnt_r <= {CNT_W{1'b0}};
        end else begin
            err_valid_r <= act_ok_s && (act_empty_s || !act_eq_s);
            if (act_ok_s && act_empty_s) begin
                err_code_r <= ERR_UNDERFLOW;
                err_ch_r   <= act_ch;
                err_exp_r  <= {DATA_W{1'b0}};
                err_act_r  <= act_data;
            end else if (act_ok_s && !act_eq_s) begin
                err_code_r <= ERR_MISMATCH;
                err_ch_r   <= act_ch;
                err_exp_r  <= head_s[act_ch];
                err_act_r  <= act_data;
            end else begin
                err_code_r <= ERR_NONE;
                err_ch_r   <= {CH_W{1'b0}};
                err_exp_r  <= {DATA_W{1'b0}};
                err_act_r  <= {DATA_W{1'b0}};
            end
            if (act_ok_s && !act_empty_s && act_eq_s) match_cnt_r <= sat_inc(match_cnt_r);
            if (act_ok_s && (act_empty_s || !act_eq_s)) mismatch_cnt_r <= sat_inc(mismatch_cnt_r);
        end
    end

    assign err_valid    = err_valid_r;
    assign err_code     = err_code_r;
    assign err_ch       = err_ch_r;
    assign err_exp      = err_exp_r;
    assign err_act      = err_act_r;
    assign match_cnt    = match_cnt_r;
    assign mismatch_cnt = mismatch_cnt_r;

endmodule

// File: tb/tb_simprisc_stream_checker.sv
// Directed scoreboard bench: stimulus queues expected error reports, a monitor
// pops and compares them whenever err_valid is seen.
module tb_simprisc_stream_checker;
    import simprisc_chk_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clear = 1'b0;
    logic        exp_valid = 1'b0;
    logic        exp_ch = 1'b0;
    logic [7:0]  exp_data = 8'h00;
    logic        exp_ready;
    logic        act_valid = 1'b0;
    logic        act_ch = 1'b0;
    logic [7:0]  act_data = 8'h00;
    logic        err_valid;
    logic [1:0]  err_code;
    logic        err_ch;
    logic [7:0]  err_exp;
    logic [7:0]  err_act;
    logic [1:0]  timeout_flags;
    logic [15:0] match_cnt;
    logic [15:0] mismatch_cnt;
    logic        empty_all;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] code;
        logic       ch;
        logic [7:0] e;
        logic [7:0] a;
    } rep_t;
    rep_t exp_q[$];
    rep_t mon_r;

    simprisc_stream_checker dut (
        .clk(clk), .rst(rst), .clear(clear),
        .exp_valid(exp_valid), .exp_ch(exp_ch), .exp_data(exp_data), .exp_ready(exp_ready),
        .act_valid(act_valid), .act_ch(act_ch), .act_data(act_data),
        .err_valid(err_valid), .err_code(err_code), .err_ch(err_ch),
        .err_exp(err_exp), .err_act(err_act), .timeout_flags(timeout_flags),
        .match_cnt(match_cnt), .mismatch_cnt(mismatch_cnt), .empty_all(empty_all)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic expect_err(input logic [1:0] code, input logic ch,
                              input logic [7:0] e, input logic [7:0] a);
        rep_t r;
        r.code = code; r.ch = ch; r.e = e; r.a = a;
        exp_q.push_back(r);
    endtask

    // one clock cycle of stimulus, returning at the following falling edge
    task automatic step(input logic ev, input logic ech, input logic [7:0] ed,
                        input logic av, input logic ach, input logic [7:0] ad,
                        input logic clr);
        exp_valid = ev; exp_ch = ech; exp_data = ed;
        act_valid = av; act_ch = ach; act_data = ad;
        clear = clr;
        @(negedge clk);
        exp_valid = 1'b0; act_valid = 1'b0; clear = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst && err_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_report code=%0d ch=%0d exp=0x%0h act=0x%0h required=none",
                         err_code, err_ch, err_exp, err_act);
            end else begin
                mon_r = exp_q.pop_front();
                check("err_code", 32'(err_code), 32'(mon_r.code));
                check("err_ch",   32'(err_ch),   32'(mon_r.ch));
                check("err_exp",  32'(err_exp),  32'(mon_r.e));
                check("err_act",  32'(err_act),  32'(mon_r.a));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values while rst is held
        #12;
        check("rst_err_valid", 32'(err_valid), 32'h0);
        check("rst_err_code",  32'(err_code),  32'h0);
        check("rst_flags",     32'(timeout_flags), 32'h0);
        check("rst_match",     32'(match_cnt), 32'h0);
        check("rst_mismatch",  32'(mismatch_cnt), 32'h0);
        check("rst_empty_all", 32'(empty_all), 32'h1);
        check("rst_ready_ch0", 32'(exp_ready), 32'h1);
        exp_ch = 1'b1; #1;
        check("rst_ready_ch1", 32'(exp_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        // in-order matches on ch0
        step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h22, 1'b0);
        check("t1_match", 32'(match_cnt), 32'd2);
        check("t1_mismatch", 32'(mismatch_cnt), 32'd0);
        check("t1_empty_all", 32'(empty_all), 32'h1);

        // mismatch on ch1
        step(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
        expect_err(2'd1, 1'b1, 8'h5A, 8'hA5);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0);
        check("t2_mismatch", 32'(mismatch_cnt), 32'd1);
        check("t2_empty_all", 32'(empty_all), 32'h1);

        // underflow with same-cycle push: value still stored
        expect_err(2'd2, 1'b0, 8'h00, 8'h33);
        step(1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 8'h33, 1'b0);
        check("t3_mismatch", 32'(mismatch_cnt), 32'd2);
        check("t3_not_empty", 32'(empty_all), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h33, 1'b0);
        check("t3_match", 32'(match_cnt), 32'd3);
        check("t3_empty_all", 32'(empty_all), 32'h1);

        // fill ch0, stall a ninth push, then drain
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0, 8'h00, 1'b0);
        exp_ch = 1'b0; #1;
        check("t4_ready_ch0_full", 32'(exp_ready), 32'h0);
        exp_ch = 1'b1; #1;
        check("t4_ready_ch1", 32'(exp_ready), 32'h1);
        step(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0);
        exp_ch = 1'b0; #1;
        check("t4_ready_ch0_after_pop", 32'(exp_ready), 32'h1);
        for (int i = 1; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'(8'h80 + i), 1'b0);
        check("t4_match", 32'(match_cnt), 32'd11);
        check("t4_empty_all", 32'(empty_all), 32'h1);

        // pointer wrap with overlapped push/pop, back-to-back actuals
        for (int i = 0; i <= 20; i++)
            step(i < 20, 1'b0, 8'(64 + i), i > 0, 1'b0, 8'(63 + i), 1'b0);
        check("t4_wrap_match", 32'(match_cnt), 32'd31);
        check("t4_wrap_mismatch", 32'(mismatch_cnt), 32'd2);

        // timeout on ch1, then clear with a discarded actual
        step(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 8'h00, 1'b0);
        repeat (63) @(negedge clk);
        check("t5_flags_age63", 32'(timeout_flags), 32'h0);
        @(negedge clk);
        check("t5_flags_age64", 32'(timeout_flags), 32'h2);
        repeat (5) @(negedge clk);
        check("t5_flags_sticky", 32'(timeout_flags), 32'h2);
        check("t5_pre_clear_empty", 32'(empty_all), 32'h0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1);
        check("t5_clear_flags", 32'(timeout_flags), 32'h0);
        check("t5_clear_empty", 32'(empty_all), 32'h1);
        check("t5_clear_match", 32'(match_cnt), 32'd0);
        check("t5_clear_mismatch", 32'(mismatch_cnt), 32'd0);

        // reset mid-stream with three entries queued
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0);
        check("t6_pre_match", 32'(match_cnt), 32'd1);
        check("t6_pre_empty", 32'(empty_all), 32'h0);
        check("t6_pre_reports", 32'(exp_q.size()), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_empty", 32'(empty_all), 32'h1);
        check("t6_rst_match", 32'(match_cnt), 32'd0);
        check("t6_rst_err_valid", 32'(err_valid), 32'h0);
        exp_ch = 1'b0; #1;
        check("t6_rst_ready", 32'(exp_ready), 32'h1);
        @(negedge clk);
        rst = 1'b0;
        expect_err(2'd2, 1'b0, 8'h00, 8'h02);
        step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h02, 1'b0);
        check("t6_underflow_cnt", 32'(mismatch_cnt), 32'd1);
        check("t6_match_after", 32'(match_cnt), 32'd0);

        repeat (2) @(negedge clk);
        check("reports_outstanding", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simprisc_stream_checker.md
# simprisc_stream_checker

Synthesisable, parametrised in-order checker for the simprisc verification environment. It queues expected values per channel and compares each arriving actual value against the oldest expected entry of its channel. It reports mismatches, underflows and per-channel timeouts, and keeps saturating pass/fail counters. It sits beside the DUT output monitor and gives the hardware/emulation build the same predictor-to-comparator check the software scoreboard performs.

## Interface
Parameters:
- DATA_W, 8, width of expected/actual data
- NUM_CH, 2, number of independent channels (≥1); CH_W = max(1, $clog2(NUM_CH))
- DEPTH, 8, expected-queue entries per channel (power of two, ≥2)
- TIMEOUT, 64, cycles a head entry may wait before timeout (≥1)
- CNT_W, 16, counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- clear  in  1  synchronous flush of all queues, counters and sticky flags
- exp_valid  in  1  expected value offered
- exp_ch  in  CH_W  channel of expected value
- exp_data  in  DATA_W  expected value
- exp_ready  out  1  selected channel queue not full
- act_valid  in  1  actual value present (always accepted, no back-pressure)
- act_ch  in  CH_W  channel of actual value
- act_data  in  DATA_W  actual value
- err_valid  out  1  one-cycle error report pulse
- err_code  out  2  err_code_t of report
- err_ch  out  CH_W  channel of report
- err_exp  out  DATA_W  expected value involved (0 for underflow)
- err_act  out  DATA_W  actual value involved
- timeout_flags  out  NUM_CH  sticky per-channel timeout
- match_cnt  out  CNT_W  saturating count of matches
- mismatch_cnt  out  CNT_W  saturating count of mismatches + underflows
- empty_all  out  1  every queue empty (end-of-test drain check)

## Operation
- Push: exp_valid && exp_ready writes exp_data to the tail of queue exp_ch. exp_valid with exp_ready low is a stall. The source holds its values.
- Pop/compare: act_valid on channel c with queue c non-empty pops the head.
  - Equal: match_cnt increments.
  - Unequal: ERR_MISMATCH report with err_exp = head and err_act = act_data; mismatch_cnt increments.
- Underflow: act_valid on an empty queue gives ERR_UNDERFLOW and increments mismatch_cnt. Nothing is popped.
- Same-cycle push and act on the same channel:
  - The compare uses the pre-push state.
  - Empty queue: underflow is reported and the pushed value is still stored.
  - Full queue with act present: exp_ready stays low (exp_ready does not depend on act).
- Timeout: each channel has an age counter.
  - Counter resets to 0 on every pop and whenever the queue is empty.
  - Otherwise it increments, saturating at TIMEOUT.
  - Reaching TIMEOUT sets timeout_flags[c]. The flag is sticky until clear or rst. The head entry is not dropped.
- Counters saturate at all-ones and never wrap.
- clear has priority over push and act in the same cycle. Inputs that cycle are discarded.
- exp_ch/act_ch ≥ NUM_CH: exp_ready = 0 and act is ignored (no report, no count).

## Timing
- exp_ready is combinational from exp_ch and the registered fill levels.
- err_* and counters are registered: the report appears in the cycle after the act_valid edge. err_valid is high for exactly one cycle.
- Back-to-back act_valid on any channels is sustained, one compare per cycle, with no bubbles.
- A value pushed at edge N is comparable by act_valid sampled at edge N+1.
- Timeout flag sets at the edge where a non-empty head has aged TIMEOUT cycles since it became head.
- Reset values (async, immediate):
  - queues empty, all age counters 0
  - err_valid 0, err_code ERR_NONE, err_ch/err_exp/err_act 0
  - timeout_flags 0, counters 0
  - empty_all 1, exp_ready 1 for any valid channel
- Reset mid-operation discards queue contents. No report is generated for discarded entries.

## Structure
- Package simprisc_chk_pkg: err_code_t enum (ERR_NONE=0, ERR_MISMATCH=1, ERR_UNDERFLOW=2), default parameter constants.
- Sub-module simprisc_chk_fifo (DATA_W, DEPTH): circular buffer with wrap-around pointers and a count field. Outputs full, empty and head. Includes the clear input. Instantiated NUM_CH times via generate.
- Top level holds the compare register stage, age counters and saturating counters.

## Test plan
- Push 0x11, 0x22 on ch0; act 0x11 then 0x22 → match_cnt=2, no err_valid, empty_all=1.
- Push 0x5A on ch1; act 0xA5 on ch1 → err_valid one cycle later with ERR_MISMATCH, err_ch=1, err_exp=0x5A, err_act=0xA5; mismatch_cnt=1.
- Act 0x33 on empty ch0 with a simultaneous push of 0x33 on ch0 → ERR_UNDERFLOW; queue holds 0x33; a later act 0x33 → match.
- Push 8 entries on ch0 (DEPTH=8) → exp_ready low for ch0 but high for ch1; one act on ch0 → exp_ready for ch0 high next cycle. Pointer wrap: 20 push/pop pairs all match.
- Push on ch1, no act for 64 cycles → timeout_flags=2'b10 exactly at age 64; clear → flags 0, queues empty, counters 0.
- Assert rst mid-stream with 3 entries queued → all outputs return to reset values immediately; the post-reset act gives an underflow.
